// File: rtl/pop_vc_pkg.sv
// Shared definitions for the VC pop arbiter: scheduling mode encodings and
// the width helper used to size index ports.
package pop_vc_pkg;

  typedef enum int unsigned {
    MODE_STRICT = 0,
    MODE_WRR    = 1
  } pop_mode_e;

  // Index width for n items; never less than one bit so ports stay legal.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/pop_vc_rr_pick.sv
// Find-first-set over a request vector, scanning upward from a rotating start
// index and wrapping modulo NUM_VC.
module pop_vc_rr_pick
  import pop_vc_pkg::*;
#(
  parameter int unsigned NUM_VC = 4
) (
  input  logic [NUM_VC-1:0]        req,
  input  logic [clog2(NUM_VC)-1:0] start,
  output logic                     found,
  output logic [clog2(NUM_VC)-1:0] idx
);

  localparam int unsigned IW = clog2(NUM_VC);

  always_comb begin
    int unsigned j;
    j     = 0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_VC; k++) begin
      j = (32'(start) + k) % NUM_VC;
      if (!found && req[IW'(j)]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/pop_delay_vcn.sv
// Pops one virtual-channel FIFO per cycle toward its destination FIFO, using
// strict priority with anti-starvation or weighted round-robin.
module pop_delay_vcn
  import pop_vc_pkg::*;
#(
  parameter int unsigned NUM_VC       = 4,
  parameter int unsigned NUM_DEST     = 2,
  parameter int unsigned MODE         = 0,
  parameter int unsigned STARVE_LIMIT = 15,
  parameter int unsigned WGT_W        = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_VC-1:0]                   vc_empty,
  input  logic [NUM_VC*clog2(NUM_DEST)-1:0]   vc_dest,
  input  logic [NUM_DEST-1:0]                 d_full,
  input  logic [NUM_VC*WGT_W-1:0]             cfg_weight,
  output logic [NUM_VC-1:0]                   vc_read,
  output logic                                grant_valid,
  output logic [clog2(NUM_VC)-1:0]            grant_id,
  output logic [NUM_VC-1:0]                   vc_delay
);

  localparam int unsigned DW = clog2(NUM_DEST);
  localparam int unsigned IW = clog2(NUM_VC);

  logic [NUM_VC-1:0] elig;
  logic [NUM_VC-1:0] dest_full;

  // An out-of-range destination makes the VC ineligible but never "delayed".
  always_comb begin
    logic [DW-1:0] dest;
    logic          dest_ok;
    dest      = '0;
    dest_ok   = 1'b0;
    elig      = '0;
    dest_full = '0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      dest         = vc_dest[i*DW +: DW];
      dest_ok      = (32'(dest) < NUM_DEST);
      dest_full[i] = dest_ok && d_full[dest];
      elig[i]      = !vc_empty[i] && dest_ok && !d_full[dest];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vc_delay <= '0;
    else       vc_delay <= ~vc_empty & dest_full;
  end

  logic [NUM_VC-1:0] pick_req;
  logic [IW-1:0]     pick_start;
  logic              pick_found;
  logic [IW-1:0]     pick_idx;
  logic              raw_valid;
  logic [IW-1:0]     raw_idx;

  pop_vc_rr_pick #(.NUM_VC(NUM_VC)) u_pick (
    .req   (pick_req),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  generate
    if (MODE == int'(MODE_WRR)) begin : g_wrr
      logic [IW-1:0]    ptr_q;
      logic [WGT_W-1:0] crd_q;
      logic             stay;
      logic [WGT_W-1:0] w_sel;
      logic [WGT_W-1:0] crd_load;

      assign stay       = elig[ptr_q] && (crd_q != '0);
      assign pick_req   = elig;
      assign pick_start = IW'((32'(ptr_q) + 32'd1) % NUM_VC);
      assign raw_valid  = stay || pick_found;
      assign raw_idx    = stay ? ptr_q : pick_idx;
      assign w_sel      = cfg_weight[32'(pick_idx)*WGT_W +: WGT_W];
      // A zero weight behaves as one: a single pop, no extra credit.
      assign crd_load   = (w_sel == '0) ? '0 : w_sel - WGT_W'(1);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ptr_q <= '0;
          crd_q <= '0;
        end else if (stay) begin
          crd_q <= crd_q - WGT_W'(1);
        end else if (pick_found) begin
          ptr_q <= pick_idx;
          crd_q <= crd_load;
        end
      end
    end else begin : g_strict
      logic [7:0]        wait_cnt [NUM_VC];
      logic [NUM_VC-1:0] starve;
      logic              cfg_unused;

      assign cfg_unused = ^cfg_weight;

      always_comb begin
        starve = '0;
        for (int unsigned i = 0; i < NUM_VC; i++)
          starve[i] = elig[i] && (wait_cnt[i] == 8'(STARVE_LIMIT));
      end

      // Starved VCs pre-empt plain priority; both resolve lowest-index first.
      assign pick_req   = (|starve) ? starve : elig;
      assign pick_start = '0;
      assign raw_valid  = pick_found;
      assign raw_idx    = pick_idx;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int unsigned i = 0; i < NUM_VC; i++) wait_cnt[i] <= '0;
        end else begin
          for (int unsigned i = 0; i < NUM_VC; i++) begin
            if (vc_empty[i] || (pick_found && pick_idx == IW'(i)))
              wait_cnt[i] <= '0;
            else if (wait_cnt[i] < 8'(STARVE_LIMIT))
              wait_cnt[i] <= wait_cnt[i] + 8'd1;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    vc_read     = '0;
    grant_valid = 1'b0;
    grant_id    = '0;
    if (!reset && raw_valid) begin
      vc_read[raw_idx] = 1'b1;
      grant_valid      = 1'b1;
      grant_id         = raw_idx;
    end
  end

endmodule

// File: tb/tb_pop_delay_vcn.sv
// Directed bench for pop_delay_vcn: one strict-priority instance and one WRR
// instance driven by the same inputs, checked against hand-computed grants.
module tb_pop_delay_vcn;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  vc_empty;
  logic [3:0]  vc_dest;
  logic [1:0]  d_full;
  logic [15:0] cfg_weight;

  logic [3:0]  s_read, w_read;
  logic        s_gv, w_gv;
  logic [1:0]  s_gid, w_gid;
  logic [3:0]  s_delay, w_delay;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pop_delay_vcn #(
    .NUM_VC(4), .NUM_DEST(2), .MODE(0), .STARVE_LIMIT(3), .WGT_W(4)
  ) u_strict (
    .clk(clk), .reset(reset), .vc_empty(vc_empty), .vc_dest(vc_dest),
    .d_full(d_full), .cfg_weight(cfg_weight), .vc_read(s_read),
    .grant_valid(s_gv), .grant_id(s_gid), .vc_delay(s_delay)
  );

  pop_delay_vcn #(
    .NUM_VC(4), .NUM_DEST(2), .MODE(1), .STARVE_LIMIT(15), .WGT_W(4)
  ) u_wrr (
    .clk(clk), .reset(reset), .vc_empty(vc_empty), .vc_dest(vc_dest),
    .d_full(d_full), .cfg_weight(cfg_weight), .vc_read(w_read),
    .grant_valid(w_gv), .grant_id(w_gid), .vc_delay(w_delay)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // idx < 0 means no grant expected; idx > 3 skips that instance.
  task automatic chk_grant(input string tag, input logic [3:0] rd, input logic gv,
                           input logic [1:0] gid, input int idx);
    if (idx > 3) return;
    if (idx < 0) begin
      chk({tag, ".read"}, 32'(rd), 32'd0);
      chk({tag, ".valid"}, 32'(gv), 32'd0);
      chk({tag, ".id"}, 32'(gid), 32'd0);
    end else begin
      chk({tag, ".read"}, 32'(rd), 32'd1 << idx);
      chk({tag, ".valid"}, 32'(gv), 32'd1);
      chk({tag, ".id"}, 32'(gid), 32'(idx));
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int exp_a_s [8] = '{0, 0, 0, 1, 2, 3, 0, 1};
  int exp_a_w [8] = '{1, 1, 2, 2, 2, 3, 0, 1};
  int exp_b_s [8] = '{0, 0, 0, 2, 0, 0, 0, 2};
  int exp_b_w [8] = '{2, 2, 2, 0, 2, 2, 2, 0};

  initial begin
    reset      = 1'b1;
    vc_empty   = 4'b0000;
    vc_dest    = 4'b0000;
    d_full     = 2'b00;
    cfg_weight = {4'd0, 4'd3, 4'd2, 4'd1};

    // Outputs forced low while reset is held, even with every VC ready.
    #12;
    chk_grant("rst_s", s_read, s_gv, s_gid, -1);
    chk_grant("rst_w", w_read, w_gv, w_gid, -1);
    chk("rst_s.delay", 32'(s_delay), 32'd0);

    // All VCs eligible: strict serves VC0 until others starve; WRR walks weights.
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk_grant($sformatf("all_s[%0d]", k), s_read, s_gv, s_gid, exp_a_s[k]);
      chk_grant($sformatf("all_w[%0d]", k), w_read, w_gv, w_gid, exp_a_w[k]);
      chk($sformatf("all_s[%0d].delay", k), 32'(s_delay), 32'd0);
      next_cycle();
    end

    // Only VC0 and VC2 populated: VC2 gets in every fourth cycle.
    vc_empty = 4'b1010;
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk_grant($sformatf("starve_s[%0d]", k), s_read, s_gv, s_gid, exp_b_s[k]);
      chk_grant($sformatf("starve_w[%0d]", k), w_read, w_gv, w_gid, exp_b_w[k]);
      next_cycle();
    end

    // VC0 heads to a full destination: skipped now, flagged delayed next cycle.
    vc_empty = 4'b0000;
    vc_dest  = 4'b0001;
    d_full   = 2'b10;
    apply_reset();
    @(negedge clk);
    chk_grant("dfull_s[0]", s_read, s_gv, s_gid, 1);
    chk_grant("dfull_w[0]", w_read, w_gv, w_gid, 1);
    chk("dfull_s[0].delay", 32'(s_delay), 32'd0);
    next_cycle();
    @(negedge clk);
    chk_grant("dfull_s[1]", s_read, s_gv, s_gid, 1);
    chk("dfull_s[1].delay", 32'(s_delay), 32'b0001);
    chk("dfull_w[1].delay", 32'(w_delay), 32'b0001);
    next_cycle();
    d_full = 2'b00;
    @(negedge clk);
    chk_grant("dfree_s", s_read, s_gv, s_gid, 0);
    chk("dfree_s.delay", 32'(s_delay), 32'b0001);
    next_cycle();
    @(negedge clk);
    chk("dfree_s.delay2", 32'(s_delay), 32'd0);
    d_full = 2'b10;
    next_cycle();
    @(negedge clk);
    chk("redelay_s", 32'(s_delay), 32'b0001);
    reset = 1'b1;
    #1;
    chk("async_rst.delay", 32'(s_delay), 32'd0);
    d_full  = 2'b00;
    vc_dest = 4'b0000;

    // WRR burst on VC2 cut short when VC2 drains; VC3 takes over with crd 0.
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_grant($sformatf("burst_w[%0d]", k), w_read, w_gv, w_gid, exp_a_w[k]);
      next_cycle();
    end
    vc_empty = 4'b0100;
    @(negedge clk);
    chk_grant("drain_w[0]", w_read, w_gv, w_gid, 3);
    next_cycle();
    @(negedge clk);
    chk_grant("drain_w[1]", w_read, w_gv, w_gid, 0);
    next_cycle();

    // Reset in the middle of a burst kills grants at once; restart from VC1.
    vc_empty = 4'b0000;
    apply_reset();
    for (int k = 0; k < 3; k++) next_cycle();
    @(negedge clk);
    chk_grant("midburst_w", w_read, w_gv, w_gid, 2);
    reset = 1'b1;
    #1;
    chk_grant("midrst_w", w_read, w_gv, w_gid, -1);
    chk_grant("midrst_s", s_read, s_gv, s_gid, -1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_grant("restart_w[0]", w_read, w_gv, w_gid, 1);
    next_cycle();
    @(negedge clk);
    chk_grant("restart_w[1]", w_read, w_gv, w_gid, 1);
    next_cycle();
    @(negedge clk);
    chk_grant("restart_w[2]", w_read, w_gv, w_gid, 2);

    // Nothing populated: no grant in either mode.
    vc_empty = 4'b1111;
    #1;
    chk_grant("idle_s", s_read, s_gv, s_gid, -1);
    chk_grant("idle_w", w_read, w_gv, w_gid, -1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
